// File: rtl/mult_result_fifo_if.sv
// Handshake bundle between the multiplier's final adder, the result buffer and
// the 64-bit result consumer.
interface mult_result_fifo_if #(
    parameter int W     = 128,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sum;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [W/2-1:0]   out_data;
    logic             out_hi;
    logic             out_carry;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_data, out_hi, out_carry, count
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_data, out_hi, out_carry, count
    );
endinterface

// File: rtl/mult_result_fifo.sv
// Product buffer: stores {carry, sum} entries and streams each one as a low
// beat followed by a high beat on a half-width bus.
module mult_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic            clk,
    input  logic            rst,
    mult_result_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = W / 2;

    typedef enum logic {LO = 1'b0, HI = 1'b1} beat_t;

    logic [W:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    beat_t         state_q, state_d;

    logic          in_ready;
    logic          out_valid;
    logic          push;
    logic          pop;
    logic          fire;
    logic [W:0]    head;
    logic [HW-1:0] out_data;
    logic          out_hi;
    logic          out_carry;

    // Ready looks only at the registered count, so a pop never raises it combinationally.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign fire      = out_valid && bus.out_ready;
    assign head      = mem_q[rp_q];

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        out_data  = '0;
        out_hi    = 1'b0;
        out_carry = 1'b0;
        if (out_valid) begin
            case (state_q)
                LO: begin
                    out_data = head[HW-1:0];
                    if (fire) state_d = HI;
                end
                HI: begin
                    out_data  = head[W-1:HW];
                    out_hi    = 1'b1;
                    out_carry = head[W];
                    if (fire) begin
                        state_d = LO;
                        pop     = 1'b1;
                    end
                end
                default: state_d = LO;
            endcase
        end
    end

    always_comb begin
        wp_d    = push ? wp_q + AW'(1) : wp_q;
        rp_d    = pop  ? rp_q + AW'(1) : rp_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            state_q <= LO;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Entry contents are only ever read while counted valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {bus.in_carry, bus.in_sum};
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_hi    = out_hi;
    assign bus.out_carry = out_carry;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_mult_result_fifo.sv
// Directed vector table plus scoreboarded streaming sequences for the
// product output buffer.
module tb_mult_result_fifo;
    localparam int W     = 128;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;

    mult_result_fifo_if #(.W(W), .DEPTH(DEPTH)) bus ();

    mult_result_fifo #(.DEPTH(DEPTH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [W-1:0]  sum;
        logic          c;
        logic          ordy;
        logic          e_ov;
        logic [63:0]   e_data;
        logic          e_hi;
        logic          e_carry;
        logic          e_ird;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   nvec = 0;
    int   nmis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic iv, input logic [W-1:0] sum, input logic c, input logic ordy,
                           input logic e_ov, input logic [63:0] e_data, input logic e_hi,
                           input logic e_carry, input logic e_ird, input int e_cnt);
        vec_t v;
        v.iv = iv; v.sum = sum; v.c = c; v.ordy = ordy;
        v.e_ov = e_ov; v.e_data = e_data; v.e_hi = e_hi; v.e_carry = e_carry;
        v.e_ird = e_ird; v.e_cnt = CW'(e_cnt);
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic ov, input logic [63:0] d,
                                 input logic hi, input logic c, input logic ird, input logic [CW-1:0] cnt);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
        chk({tag, ".out_data"},  bus.out_data,       d);
        chk({tag, ".out_hi"},    64'(bus.out_hi),    64'(hi));
        chk({tag, ".out_carry"}, 64'(bus.out_carry), 64'(c));
        chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(ird));
        chk({tag, ".count"},     64'(bus.count),     64'(cnt));
    endtask

    // Scoreboarded stream: rnd=1 randomises in_valid/out_ready, rnd=0 runs both at full rate.
    task automatic run_stream(input string tag, input int n, input bit rnd);
        logic [W:0]  model_q[$];
        logic [W:0]  pend;
        int          sent = 0;
        int          got = 0;
        int          maxc = 0;
        bit          phase = 1'b0;
        bit          acc, fire;
        bit          prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        logic        prev_hi = 1'b0;
        logic        prev_c = 1'b0;
        logic [W:0]  h;
        pend = {1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), $urandom()};
        for (int cyc = 0; cyc < 4000 && got < n; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            bus.in_sum    = pend[W-1:0];
            bus.in_carry  = pend[W];
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (model_q.size() != 0) begin
                h = model_q[0];
                check_outputs(tag, 1'b1, phase ? h[W-1:64] : h[63:0], phase, phase ? h[W] : 1'b0,
                              model_q.size() < DEPTH, CW'(model_q.size()));
            end else begin
                check_outputs(tag, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, '0);
            end
            if (prev_stall) begin
                chk({tag, ".stall_data"}, bus.out_data, prev_data);
                chk({tag, ".stall_hi"}, 64'(bus.out_hi), 64'(prev_hi));
                chk({tag, ".stall_carry"}, 64'(bus.out_carry), 64'(prev_c));
            end
            acc        = bus.in_valid && (model_q.size() < DEPTH);
            fire       = (model_q.size() != 0) && bus.out_ready;
            prev_stall = (model_q.size() != 0) && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_hi    = bus.out_hi;
            prev_c     = bus.out_carry;
            if (model_q.size() > maxc) maxc = model_q.size();
            @(posedge clk);
            if (fire) begin
                if (phase) begin
                    h = model_q.pop_front();
                    got++;
                    $display("%s rx %0d sum=%h carry=%b", tag, got, h[W-1:0], h[W]);
                end
                phase = ~phase;
            end
            if (acc) begin
                model_q.push_back(pend);
                sent++;
                pend = {1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        chk({tag, ".products_received"}, 64'(got), 64'(n));
        if (!rnd) chk({tag, ".max_count"}, 64'(maxc), 64'(DEPTH));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state while reset is held
        #2;
        check_outputs("reset", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, '0);
        @(negedge clk);
        rst = 1'b0;

        // Single product, then fill to DEPTH with a fifth push held off, then drain
        add_vec(1, 128'h0123456789ABCDEF_FEDCBA9876543210, 1, 1, 0, 64'h0, 0, 0, 1, 0);
        add_vec(0, '0, 0, 1, 1, 64'hFEDCBA9876543210, 0, 0, 1, 1);
        add_vec(0, '0, 0, 1, 1, 64'h0123456789ABCDEF, 1, 1, 1, 1);
        add_vec(0, '0, 0, 1, 0, 64'h0, 0, 0, 1, 0);
        add_vec(1, 128'h00000000000000A1_00000000000000B1, 1, 0, 0, 64'h0, 0, 0, 1, 0);
        add_vec(1, 128'h00000000000000A2_00000000000000B2, 0, 0, 1, 64'hB1, 0, 0, 1, 1);
        add_vec(1, 128'h00000000000000A3_00000000000000B3, 1, 0, 1, 64'hB1, 0, 0, 1, 2);
        add_vec(1, 128'h00000000000000A4_00000000000000B4, 0, 0, 1, 64'hB1, 0, 0, 1, 3);
        add_vec(1, 128'h00000000000000A5_00000000000000B5, 1, 0, 1, 64'hB1, 0, 0, 0, 4);
        add_vec(1, 128'h00000000000000A5_00000000000000B5, 1, 1, 1, 64'hB1, 0, 0, 0, 4);
        add_vec(1, 128'h00000000000000A5_00000000000000B5, 1, 1, 1, 64'hA1, 1, 1, 0, 4);
        add_vec(1, 128'h00000000000000A5_00000000000000B5, 1, 1, 1, 64'hB2, 0, 0, 1, 3);
        add_vec(0, '0, 0, 1, 1, 64'hA2, 1, 0, 0, 4);
        add_vec(0, '0, 0, 1, 1, 64'hB3, 0, 0, 1, 3);
        add_vec(0, '0, 0, 1, 1, 64'hA3, 1, 1, 1, 3);
        add_vec(0, '0, 0, 1, 1, 64'hB4, 0, 0, 1, 2);
        add_vec(0, '0, 0, 1, 1, 64'hA4, 1, 0, 1, 2);
        add_vec(0, '0, 0, 1, 1, 64'hB5, 0, 0, 1, 1);
        add_vec(0, '0, 0, 1, 1, 64'hA5, 1, 1, 1, 1);
        add_vec(0, '0, 0, 0, 0, 64'h0, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.in_valid  = vecs[i].iv;
            bus.in_sum    = vecs[i].sum;
            bus.in_carry  = vecs[i].c;
            bus.out_ready = vecs[i].ordy;
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_data, vecs[i].e_hi,
                          vecs[i].e_carry, vecs[i].e_ird, vecs[i].e_cnt);
            $display("vec %0d: out_valid=%b out_data=%h out_hi=%b count=%0d",
                     i, bus.out_valid, bus.out_data, bus.out_hi, bus.count);
        end

        // Asynchronous reset asserted mid-cycle with entries stored
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_sum    = 128'h1111;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, '0);
        @(negedge clk);
        rst = 1'b0;

        // Reset between LO and HI beats of one entry
        bus.in_valid = 1'b1;
        bus.in_sum   = {64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA};
        bus.in_carry = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_outputs("mid_lo", 1'b1, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b0, 1'b1, CW'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_outputs("mid_rst", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, '0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 128'h1;
        bus.in_carry  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_outputs("post_rst_idle", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, '0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check_outputs("post_rst_lo", 1'b1, 64'h1, 1'b0, 1'b0, 1'b1, CW'(1));
        @(negedge clk);
        #1;
        check_outputs("post_rst_hi", 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, CW'(1));
        @(negedge clk);
        #1;
        check_outputs("post_rst_empty", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, '0);
        bus.out_ready = 1'b0;

        run_stream("wrap", 20, 1'b0);
        run_stream("backpressure", 100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
